eve_gene_collector: RTL and testbench
=====================================

Name: eve_gene_collector

Overview:
- Consumer end of the EvE child-gene output bus: captures one wide child-gene burst (NUM_PE lanes × 64 bits) produced after a parent write.
- Drains the enabled lanes, one 64-bit gene per beat, onto a valid/ready stream toward genome writeback memory.
- Sits between the EvE out1/out2/out3 buses (one instance per bus) and the writeback arbiter.

Parameters:
- NUM_PE, 8, number of PE lanes in the input bus.
- GENE_W, 64, width of one gene word.
- CNT_W, 16, width of the emitted-gene counter.

Ports:
- input_clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- child_bus  in  NUM_PE*GENE_W  child genes; lane i occupies bits [i*GENE_W +: GENE_W].
- child_valid  in  1  single-cycle strobe; child_bus and lane_mask are valid this cycle.
- lane_mask  in  NUM_PE  bit i=1: lane i holds a gene to forward.
- m_gene  out  GENE_W  current output gene.
- m_lane  out  $clog2(NUM_PE)  source lane index of m_gene.
- m_valid  out  1  m_gene/m_lane valid.
- m_ready  in  1  downstream accepts the beat when m_valid&&m_ready.
- m_last  out  1  asserted with the final gene of a burst.
- busy  out  1  snapshot held / drain in progress.
- overrun  out  1  sticky; a burst was dropped.
- gene_count  out  CNT_W  total genes accepted downstream; wraps modulo 2^CNT_W.
- clr_status  in  1  synchronous clear of overrun and gene_count.

Behaviour:
- Reset (reset=0, asynchronous): all outputs 0; snapshot and pending mask cleared; FSM=IDLE.
- FSM has two states, IDLE and DRAIN.
- IDLE:
  - On child_valid with lane_mask≠0: register child_bus into the snapshot and lane_mask into pend; go to DRAIN next cycle.
  - child_valid with lane_mask==0 is ignored (no state change, no overrun).
- DRAIN:
  - m_valid=1. m_lane = lowest set bit of pend; m_gene = snapshot lane m_lane.
  - m_last=1 when pend has exactly one bit set.
  - First m_valid is the cycle after the capture strobe (latency 1).
  - On m_valid&&m_ready: clear that pend bit; gene_count+1.
  - If that was the last bit, return to IDLE next cycle (m_valid=0 that cycle).
  - Otherwise the next lane is presented next cycle; throughput is 1 gene/cycle with m_ready held high.
  - m_ready=0: m_gene, m_lane, m_last and m_valid hold stable (no retraction).
- busy = (state==DRAIN).
- child_valid while DRAIN (without the optional feature): burst dropped, overrun←1, current drain unaffected.
- Same-cycle last handshake plus child_valid: counts as busy → dropped/overrun. The new burst is not captured until IDLE.
- clr_status:
  - Clears overrun and gene_count next edge.
  - If a handshake occurs in the same cycle, gene_count←1 (the increment wins over the clear); overrun←0 unless a drop occurs the same cycle, in which case overrun←1.
- Reset mid-drain: remaining genes discarded; m_valid drops asynchronously.

Optional Feature:
- Macro GENE_COLLECT_SKIDBUF_EN.
- Defined:
  - Adds a second snapshot/mask buffer.
  - child_valid during DRAIN with the buffer empty stores the burst there; overrun is not set.
  - When the active drain finishes (last handshake), the buffered burst becomes active. Its first gene is presented the very next cycle; no IDLE bubble.
  - A burst arriving while both buffers are full is dropped and sets overrun.
  - busy=1 while either buffer is occupied.
- Undefined: single buffer, behaviour as above.

Test Plan:
- Basic drain: child_valid with lane_mask=8'b1010_0101, lane0=64'hC82000F722222222, m_ready=1 → beats on lanes 0,2,5,7 in consecutive cycles starting 1 cycle after the strobe; first m_gene=64'hC82000F722222222; m_last only on lane 7; gene_count=4; busy deasserts after the 4th beat.
- Backpressure: mask=8'h03, m_ready low for 3 cycles → lane 0 beat held stable for 3 cycles; accepted on the 4th; lane 1 follows; gene_count=2.
- Overrun (macro undefined): second child_valid 1 cycle after the first (mask=8'hFF) → second burst dropped; overrun=1; 8 beats from the first burst only. With the macro defined: 16 beats, no gap between bursts, overrun=0.
- Empty mask: child_valid with lane_mask=0 → no m_valid; busy=0; overrun=0.
- Reset mid-operation: assert reset after 2 of 8 beats → m_valid=0 immediately; gene_count=0; a new burst afterward drains normally from its lowest set lane.
- Counter wrap / clear: preload by 65535 accepted beats, then one more → gene_count=0; clr_status in the same cycle as a handshake → gene_count=1.

Source files
------------

// File: rtl/eve_gene_collector.sv
`timescale 1ns/1ps
// eve_gene_collector: captures one NUM_PE-lane child-gene burst and drains the
// enabled lanes, lowest lane first, as a valid/ready stream of GENE_W-bit genes.
// Optional: define GENE_COLLECT_SKIDBUF_EN to add a second burst buffer, so that
// a burst arriving mid-drain is held instead of being dropped.
module eve_gene_collector #(
    parameter int unsigned NUM_PE = 8,
    parameter int unsigned GENE_W = 64,
    parameter int unsigned CNT_W  = 16
) (
    input  logic                       input_clk,
    input  logic                       reset,
    input  logic [NUM_PE*GENE_W-1:0]   child_bus,
    input  logic                       child_valid,
    input  logic [NUM_PE-1:0]          lane_mask,
    output logic [GENE_W-1:0]          m_gene,
    output logic [$clog2(NUM_PE)-1:0]  m_lane,
    output logic                       m_valid,
    input  logic                       m_ready,
    output logic                       m_last,
    output logic                       busy,
    output logic                       overrun,
    output logic [CNT_W-1:0]           gene_count,
    input  logic                       clr_status
);
    localparam int unsigned LaneW = $clog2(NUM_PE);

    typedef enum logic {StIdle, StDrain} state_e;

    state_e                   state_q, state_d;
    logic [NUM_PE*GENE_W-1:0] snap_q, snap_d;
    logic [NUM_PE-1:0]        pend_q, pend_d;
    logic                     overrun_q, overrun_d;
    logic [CNT_W-1:0]         count_q, count_d;
`ifdef GENE_COLLECT_SKIDBUF_EN
    // A non-zero pend2_q marks the second buffer as occupied.
    logic [NUM_PE*GENE_W-1:0] snap2_q, snap2_d;
    logic [NUM_PE-1:0]        pend2_q, pend2_d;
`endif
    logic [LaneW-1:0]         low_lane;
    logic                     new_burst, hs, last_hs, drop;

    // Lowest pending lane; scanned downward so the smallest index wins.
    always_comb begin
        low_lane = '0;
        for (int i = NUM_PE - 1; i >= 0; i--) begin
            if (pend_q[i]) low_lane = LaneW'(i);
        end
    end

    assign m_valid    = (state_q == StDrain);
    assign m_lane     = m_valid ? low_lane : '0;
    assign m_gene     = m_valid ? snap_q[int'(low_lane)*GENE_W +: GENE_W] : '0;
    // Exactly one bit left: clearing the lowest set bit leaves nothing.
    assign m_last     = m_valid && ((pend_q & (pend_q - NUM_PE'(1))) == '0);
    // The second buffer is only ever filled while draining, so DRAIN covers both.
    assign busy       = m_valid;
    assign overrun    = overrun_q;
    assign gene_count = count_q;

    assign new_burst  = child_valid && (lane_mask != '0);
    assign hs         = m_valid && m_ready;
    assign last_hs    = hs && m_last;

    // Next-state: capture, drain bookkeeping, drop detection and status counters.
    always_comb begin
        state_d   = state_q;
        snap_d    = snap_q;
        pend_d    = pend_q;
        overrun_d = overrun_q;
        count_d   = count_q;
        drop      = 1'b0;
`ifdef GENE_COLLECT_SKIDBUF_EN
        snap2_d   = snap2_q;
        pend2_d   = pend2_q;
`endif
        if (hs) begin
            pend_d  = pend_q & ~(NUM_PE'(1) << low_lane);
            // An accepted beat outranks a same-cycle clear.
            count_d = clr_status ? CNT_W'(1) : count_q + CNT_W'(1);
        end else if (clr_status) begin
            count_d = '0;
        end
        if (clr_status) overrun_d = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (new_burst) begin
                    snap_d  = child_bus;
                    pend_d  = lane_mask;
                    state_d = StDrain;
                end
            end
            StDrain: begin
`ifdef GENE_COLLECT_SKIDBUF_EN
                if (last_hs) begin
                    if (pend2_q != '0) begin
                        // Promote the held burst; both buffers were full this cycle.
                        snap_d  = snap2_q;
                        pend_d  = pend2_q;
                        pend2_d = '0;
                        drop    = new_burst;
                    end else if (new_burst) begin
                        // Active drain ends now, so go straight to the new burst.
                        snap_d  = child_bus;
                        pend_d  = lane_mask;
                    end else begin
                        state_d = StIdle;
                    end
                end else if (new_burst) begin
                    if (pend2_q == '0) begin
                        snap2_d = child_bus;
                        pend2_d = lane_mask;
                    end else begin
                        drop = 1'b1;
                    end
                end
`else
                drop = new_burst;
                if (last_hs) state_d = StIdle;
`endif
            end
            default: state_d = StIdle;
        endcase

        if (drop) overrun_d = 1'b1;
    end

    // State registers, cleared asynchronously.
    always_ff @(posedge input_clk or negedge reset) begin
        if (!reset) begin
            state_q   <= StIdle;
            snap_q    <= '0;
            pend_q    <= '0;
            overrun_q <= 1'b0;
            count_q   <= '0;
`ifdef GENE_COLLECT_SKIDBUF_EN
            snap2_q   <= '0;
            pend2_q   <= '0;
`endif
        end else begin
            state_q   <= state_d;
            snap_q    <= snap_d;
            pend_q    <= pend_d;
            overrun_q <= overrun_d;
            count_q   <= count_d;
`ifdef GENE_COLLECT_SKIDBUF_EN
            snap2_q   <= snap2_d;
            pend2_q   <= pend2_d;
`endif
        end
    end

endmodule

// File: tb/tb_eve_gene_collector.sv
`timescale 1ns/1ps
// Testbench for eve_gene_collector: table-driven basic drain, hand-written corner
// sequences and randomized traffic, all checked against a beat-queue model.
module tb_eve_gene_collector;
    localparam int NUM_PE = 8;
    localparam int GENE_W = 64;
    localparam int CNT_W  = 16;
`ifdef GENE_COLLECT_SKIDBUF_EN
    localparam int CAP = 2;
`else
    localparam int CAP = 1;
`endif

    logic                      input_clk = 1'b0;
    logic                      reset = 1'b0;
    logic [NUM_PE*GENE_W-1:0]  child_bus = '0;
    logic                      child_valid = 1'b0;
    logic [NUM_PE-1:0]         lane_mask = '0;
    logic [GENE_W-1:0]         m_gene;
    logic [2:0]                m_lane;
    logic                      m_valid;
    logic                      m_ready = 1'b0;
    logic                      m_last;
    logic                      busy;
    logic                      overrun;
    logic [CNT_W-1:0]          gene_count;
    logic                      clr_status = 1'b0;

    eve_gene_collector #(.NUM_PE(NUM_PE), .GENE_W(GENE_W), .CNT_W(CNT_W)) dut (
        .input_clk  (input_clk),
        .reset      (reset),
        .child_bus  (child_bus),
        .child_valid(child_valid),
        .lane_mask  (lane_mask),
        .m_gene     (m_gene),
        .m_lane     (m_lane),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_last     (m_last),
        .busy       (busy),
        .overrun    (overrun),
        .gene_count (gene_count),
        .clr_status (clr_status)
    );

    always #5 input_clk = ~input_clk;

    // Model: every accepted burst becomes a list of beats in drain order.
    typedef struct {
        logic [2:0]  lane;
        logic [63:0] gene;
        logic        last;
    } beat_t;

    beat_t       q[$];
    int unsigned mdl_count;
    bit          mdl_overrun;
    int          total = 0;
    int          bad = 0;

    typedef struct {
        logic        cv;
        logic [7:0]  mask;
        logic        rdy;
        logic        clr;
        logic        ev;
        logic [2:0]  elane;
        logic        elast;
        logic        ebusy;
        logic [15:0] ecount;
    } vec_t;

    vec_t tbl[6];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [511:0] mk_bus(input logic [63:0] seed);
        logic [511:0] b;
        for (int i = 0; i < NUM_PE; i++) b[i*64 +: 64] = seed ^ {8{8'(i)}};
        return b;
    endfunction

    function automatic logic [511:0] rnd_bus();
        logic [511:0] b;
        for (int i = 0; i < 16; i++) b[i*32 +: 32] = $urandom;
        return b;
    endfunction

    // One clock: drive inputs on the falling edge, compare, then advance the model.
    task automatic do_cycle(input logic cv, input logic [511:0] bus, input logic [7:0] mask,
                            input logic rdy, input logic clr);
        int    nb;
        bit    ev, hs, newb, drop;
        beat_t b;
        @(negedge input_clk);
        child_valid = cv;
        child_bus   = bus;
        lane_mask   = mask;
        m_ready     = rdy;
        clr_status  = clr;
        #1;
        ev = (q.size() > 0);
        check("m_valid", 64'(m_valid), 64'(ev));
        check("busy", 64'(busy), 64'(ev));
        check("overrun", 64'(overrun), 64'(mdl_overrun));
        check("gene_count", 64'(gene_count), 64'(mdl_count));
        if (ev) begin
            check("m_lane", 64'(m_lane), 64'(q[0].lane));
            check("m_gene", m_gene, q[0].gene);
            check("m_last", 64'(m_last), 64'(q[0].last));
        end else begin
            check("m_last_idle", 64'(m_last), 64'd0);
        end
        nb = 0;
        foreach (q[i]) if (q[i].last) nb++;
        hs   = ev && rdy;
        newb = cv && (mask != 8'h00);
        drop = newb && (nb >= CAP);
        if (hs) begin
            q.delete(0);
            mdl_count = clr ? 1 : (mdl_count + 1) % 65536;
        end else if (clr) begin
            mdl_count = 0;
        end
        if (drop) mdl_overrun = 1'b1;
        else if (clr) mdl_overrun = 1'b0;
        if (newb && !drop) begin
            for (int i = 0; i < NUM_PE; i++) begin
                if (mask[i]) begin
                    b.lane = 3'(i);
                    b.gene = bus[i*64 +: 64];
                    b.last = ((mask >> (i + 1)) == 8'h00);
                    q.push_back(b);
                end
            end
        end
    endtask

    task automatic do_reset();
        @(negedge input_clk);
        child_valid = 1'b0;
        m_ready     = 1'b0;
        clr_status  = 1'b0;
        reset       = 1'b0;
        #1;
        check("rst_m_valid", 64'(m_valid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_gene_count", 64'(gene_count), 64'd0);
        check("rst_overrun", 64'(overrun), 64'd0);
        check("rst_m_gene", m_gene, 64'd0);
        q.delete();
        mdl_count   = 0;
        mdl_overrun = 1'b0;
        #2 reset = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [511:0] bus_a, bus_b;
        int           beats;

        tbl[0] = '{cv:1'b1, mask:8'hA5, rdy:1'b1, clr:1'b0, ev:1'b0, elane:3'd0, elast:1'b0,
                   ebusy:1'b0, ecount:16'd0};
        tbl[1] = '{cv:1'b0, mask:8'h00, rdy:1'b1, clr:1'b0, ev:1'b1, elane:3'd0, elast:1'b0,
                   ebusy:1'b1, ecount:16'd0};
        tbl[2] = '{cv:1'b0, mask:8'h00, rdy:1'b1, clr:1'b0, ev:1'b1, elane:3'd2, elast:1'b0,
                   ebusy:1'b1, ecount:16'd1};
        tbl[3] = '{cv:1'b0, mask:8'h00, rdy:1'b1, clr:1'b0, ev:1'b1, elane:3'd5, elast:1'b0,
                   ebusy:1'b1, ecount:16'd2};
        tbl[4] = '{cv:1'b0, mask:8'h00, rdy:1'b1, clr:1'b0, ev:1'b1, elane:3'd7, elast:1'b1,
                   ebusy:1'b1, ecount:16'd3};
        tbl[5] = '{cv:1'b0, mask:8'h00, rdy:1'b1, clr:1'b0, ev:1'b0, elane:3'd0, elast:1'b0,
                   ebusy:1'b0, ecount:16'd4};

        q.delete();
        mdl_count   = 0;
        mdl_overrun = 1'b0;

        // Reset state.
        #3;
        check("reset_m_valid", 64'(m_valid), 64'd0);
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_overrun", 64'(overrun), 64'd0);
        check("reset_gene_count", 64'(gene_count), 64'd0);
        #9 reset = 1'b1;

        // Basic drain, mask 1010_0101.
        bus_a = mk_bus(64'hC82000F722222222);
        for (int r = 0; r < 6; r++) begin
            do_cycle(tbl[r].cv, bus_a, tbl[r].mask, tbl[r].rdy, tbl[r].clr);
            check("tbl_valid", 64'(m_valid), 64'(tbl[r].ev));
            check("tbl_busy", 64'(busy), 64'(tbl[r].ebusy));
            check("tbl_count", 64'(gene_count), 64'(tbl[r].ecount));
            if (tbl[r].ev) begin
                check("tbl_lane", 64'(m_lane), 64'(tbl[r].elane));
                check("tbl_last", 64'(m_last), 64'(tbl[r].elast));
            end
            if (r == 1) check("tbl_first_gene", m_gene, 64'hC82000F722222222);
        end

        // Backpressure: lane 0 held for three stalled cycles.
        do_reset();
        bus_a = rnd_bus();
        do_cycle(1'b1, bus_a, 8'h03, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            do_cycle(1'b0, bus_a, 8'h00, 1'b0, 1'b0);
            check("bp_hold_valid", 64'(m_valid), 64'd1);
            check("bp_hold_lane", 64'(m_lane), 64'd0);
            check("bp_hold_gene", m_gene, bus_a[63:0]);
        end
        do_cycle(1'b0, bus_a, 8'h00, 1'b1, 1'b0);
        do_cycle(1'b0, bus_a, 8'h00, 1'b1, 1'b0);
        check("bp_lane1", 64'(m_lane), 64'd1);
        check("bp_lane1_last", 64'(m_last), 64'd1);
        do_cycle(1'b0, bus_a, 8'h00, 1'b1, 1'b0);
        check("bp_count", 64'(gene_count), 64'd2);

        // Overrun: a second full burst one cycle after the first.
        do_reset();
        bus_a = rnd_bus();
        bus_b = rnd_bus();
        do_cycle(1'b1, bus_a, 8'hFF, 1'b1, 1'b0);
        beats = 0;
        do_cycle(1'b1, bus_b, 8'hFF, 1'b1, 1'b0);
        if (m_valid) beats++;
        for (int i = 0; i < 18; i++) begin
            do_cycle(1'b0, bus_a, 8'h00, 1'b1, 1'b0);
            if (m_valid) beats++;
        end
        check("ovr_beats", 64'(beats), 64'(8 * CAP));
        check("ovr_flag", 64'(overrun), (CAP == 1) ? 64'd1 : 64'd0);
        do_cycle(1'b0, bus_a, 8'h00, 1'b0, 1'b1);
        do_cycle(1'b0, bus_a, 8'h00, 1'b0, 1'b0);
        check("ovr_cleared", 64'(overrun), 64'd0);

        // Empty mask is ignored.
        do_reset();
        do_cycle(1'b1, rnd_bus(), 8'h00, 1'b1, 1'b0);
        do_cycle(1'b0, '0, 8'h00, 1'b1, 1'b0);
        check("empty_valid", 64'(m_valid), 64'd0);
        check("empty_busy", 64'(busy), 64'd0);
        check("empty_overrun", 64'(overrun), 64'd0);

        // Reset after two of eight beats, then a fresh burst from lane 4.
        do_reset();
        bus_a = rnd_bus();
        do_cycle(1'b1, bus_a, 8'hFF, 1'b1, 1'b0);
        do_cycle(1'b0, bus_a, 8'h00, 1'b1, 1'b0);
        do_cycle(1'b0, bus_a, 8'h00, 1'b1, 1'b0);
        do_reset();
        bus_b = rnd_bus();
        do_cycle(1'b1, bus_b, 8'h30, 1'b1, 1'b0);
        do_cycle(1'b0, bus_b, 8'h00, 1'b1, 1'b0);
        check("post_rst_lane", 64'(m_lane), 64'd4);
        check("post_rst_gene", m_gene, bus_b[4*64 +: 64]);
        do_cycle(1'b0, bus_b, 8'h00, 1'b1, 1'b0);
        do_cycle(1'b0, bus_b, 8'h00, 1'b1, 1'b0);
        check("post_rst_count", 64'(gene_count), 64'd2);

        // Counter wrap: 65535 beats, then one more; then clear vs handshake.
        do_reset();
        bus_a = mk_bus(64'h0123_4567_89AB_CDEF);
        for (int b = 0; b < 8191; b++) begin
            do_cycle(1'b1, bus_a, 8'hFF, 1'b1, 1'b0);
            for (int i = 0; i < 8; i++) do_cycle(1'b0, bus_a, 8'h00, 1'b1, 1'b0);
        end
        do_cycle(1'b1, bus_a, 8'hFF, 1'b1, 1'b0);
        for (int i = 0; i < 8; i++) do_cycle(1'b0, bus_a, 8'h00, 1'b1, 1'b0);
        check("wrap_max", 64'(gene_count), 64'd65535);
        do_cycle(1'b0, bus_a, 8'h00, 1'b1, 1'b0);
        check("wrap_zero", 64'(gene_count), 64'd0);
        do_cycle(1'b1, bus_a, 8'h03, 1'b1, 1'b0);
        do_cycle(1'b0, bus_a, 8'h00, 1'b1, 1'b1);
        do_cycle(1'b0, bus_a, 8'h00, 1'b0, 1'b0);
        check("clr_with_hs", 64'(gene_count), 64'd1);
        do_cycle(1'b0, bus_a, 8'h00, 1'b1, 1'b0);
        do_cycle(1'b0, bus_a, 8'h00, 1'b0, 1'b1);
        do_cycle(1'b0, bus_a, 8'h00, 1'b0, 1'b0);
        check("clr_alone", 64'(gene_count), 64'd0);

        // Randomized traffic against the model.
        do_reset();
        for (int i = 0; i < 600; i++) begin
            do_cycle(($urandom_range(0, 3) == 0), rnd_bus(),
                     ($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom),
                     ($urandom_range(0, 3) != 0), ($urandom_range(0, 19) == 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
